// File: rtl/systolic_mmu_seq.sv
// rtl/systolic_mmu_seq.sv - clear/feed/drain/readout sequencer for an NxN FP8 systolic MAC array
// Define MMU_SEQ_PERF_EN to build the busy-cycle performance counter behind perf_cycles.
module systolic_mmu_seq #(
    parameter int N  = 4,
    parameter int KW = 8,
    parameter int AW = 8,
    localparam int RW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    output logic            busy,
    output logic            done,
    output logic            op_rd_en,
    output logic [AW-1:0]   op_rd_addr,
    input  logic [8*N-1:0]  a_rd_data,
    input  logic [8*N-1:0]  b_rd_data,
    output logic            arr_clear,
    output logic [8*N-1:0]  arr_a_west,
    output logic [8*N-1:0]  arr_b_north,
    output logic [RW-1:0]   arr_row_sel,
    input  logic [16*N-1:0] arr_c_row,
    output logic            c_valid,
    input  logic            c_ready,
    output logic [RW-1:0]   c_row,
    output logic [16*N-1:0] c_data,
    output logic [31:0]     perf_cycles
);
    localparam int DW = $clog2(2 * N + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_READOUT, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [KW-1:0] k_lat;
    logic [AW-1:0] addr;
    logic [RW-1:0] row;
    logic [DW-1:0] dcnt;
    logic          rd_en_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            k_lat   <= '0;
            addr    <= '0;
            row     <= '0;
            dcnt    <= '0;
            rd_en_d <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_en_d <= op_rd_en;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_lat <= k_len;
                        addr  <= '0;
                        row   <= '0;
                        dcnt  <= '0;
                    end
                end
                S_FEED:  addr <= addr + AW'(1);
                S_DRAIN: dcnt <= dcnt + DW'(1);
                S_READOUT: begin
                    if (c_ready) row <= (row == RW'(N - 1)) ? '0 : row + RW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        op_rd_en  = 1'b0;
        arr_clear = 1'b0;
        c_valid   = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                arr_clear = 1'b1;
                // A zero-length job has nothing to stream; cleared accumulators read back as zero.
                state_nxt = (k_lat == '0) ? S_READOUT : S_FEED;
            end
            S_FEED: begin
                op_rd_en = 1'b1;
                if (addr == AW'(k_lat) - AW'(1)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (dcnt == DW'(2 * N - 1)) state_nxt = S_READOUT;
            end
            S_READOUT: begin
                c_valid = 1'b1;
                if (c_ready && row == RW'(N - 1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign op_rd_addr  = addr;
    assign arr_row_sel = row;
    assign c_row       = row;
    assign c_data      = arr_c_row;

    // Lane i is delayed i cycles; bytes outside the read-data window are forced to FP8 +0.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [7:0] a_in, b_in;
        assign a_in = rd_en_d ? a_rd_data[8*i +: 8] : 8'h00;
        assign b_in = rd_en_d ? b_rd_data[8*i +: 8] : 8'h00;
        if (i == 0) begin : g_direct
            assign arr_a_west[7:0]  = a_in;
            assign arr_b_north[7:0] = b_in;
        end else begin : g_skew
            logic [7:0] a_sh [i];
            logic [7:0] b_sh [i];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < i; d++) begin
                        a_sh[d] <= 8'h00;
                        b_sh[d] <= 8'h00;
                    end
                end else begin
                    a_sh[0] <= a_in;
                    b_sh[0] <= b_in;
                    for (int d = 1; d < i; d++) begin
                        a_sh[d] <= a_sh[d-1];
                        b_sh[d] <= b_sh[d-1];
                    end
                end
            end
            assign arr_a_west[8*i +: 8]  = a_sh[i-1];
            assign arr_b_north[8*i +: 8] = b_sh[i-1];
        end
    end

`ifdef MMU_SEQ_PERF_EN
    logic [31:0] perf_cnt;
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt <= '0;
            perf_q   <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                perf_cnt <= '0;
            end else if (busy && perf_cnt != 32'hFFFF_FFFF) begin
                perf_cnt <= perf_cnt + 32'd1;
            end
            // The DONE cycle itself is counted in the reported value.
            if (state == S_DONE) begin
                perf_q <= (perf_cnt == 32'hFFFF_FFFF) ? perf_cnt : perf_cnt + 32'd1;
            end
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_systolic_mmu_seq.sv
// tb/tb_systolic_mmu_seq.sv - self-checking bench for systolic_mmu_seq with a behavioural PE grid
module tb_systolic_mmu_seq;
    localparam int N    = 4;
    localparam int KW   = 8;
    localparam int AW   = 8;
    localparam int MAXK = 16;

    logic            clk = 1'b0;
    logic            rst, start, c_ready;
    logic [KW-1:0]   k_len;
    logic            busy, done, op_rd_en, arr_clear, c_valid;
    logic [AW-1:0]   op_rd_addr;
    logic [8*N-1:0]  a_rd_data, b_rd_data, arr_a_west, arr_b_north;
    logic [1:0]      arr_row_sel, c_row;
    logic [16*N-1:0] arr_c_row, c_data;
    logic [31:0]     perf_cycles;

    systolic_mmu_seq #(.N(N), .KW(KW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .busy(busy), .done(done), .op_rd_en(op_rd_en), .op_rd_addr(op_rd_addr),
        .a_rd_data(a_rd_data), .b_rd_data(b_rd_data), .arr_clear(arr_clear),
        .arr_a_west(arr_a_west), .arr_b_north(arr_b_north), .arr_row_sel(arr_row_sel),
        .arr_c_row(arr_c_row), .c_valid(c_valid), .c_ready(c_ready), .c_row(c_row),
        .c_data(c_data), .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic real fp8r(input logic [7:0] x);
        int  e, m;
        real v;
        e = int'(x[6:3]);
        m = int'(x[2:0]);
        if (e == 0) v = (m / 8.0) * (2.0 ** (-6));
        else        v = (1.0 + m / 8.0) * (2.0 ** (e - 7));
        return x[7] ? -v : v;
    endfunction

    function automatic logic [15:0] bf16(input real r);
        logic [63:0] b;
        int          ex;
        b = $realtobits(r);
        if (b[62:0] == 63'd0) return {b[63], 15'h0};
        ex = int'(b[62:52]) - 1023 + 127;
        return {b[63], ex[7:0], b[51:45]};
    endfunction

    // Operand buffers: A[i][k] at a_mem[k][i], B[k][j] at b_mem[k][j]; nonzero junk outside valid beats.
    logic [7:0] a_mem [MAXK][N];
    logic [7:0] b_mem [MAXK][N];
    logic       rd_v = 1'b0;
    logic [3:0] rd_k = 4'd0;

    always @(posedge clk) begin
        rd_v <= op_rd_en;
        rd_k <= op_rd_addr[3:0];
    end

    always_comb begin
        a_rd_data = '0;
        b_rd_data = '0;
        for (int i = 0; i < N; i++) begin
            a_rd_data[8*i +: 8] = rd_v ? a_mem[rd_k][i] : 8'h38;
            b_rd_data[8*i +: 8] = rd_v ? b_mem[rd_k][i] : 8'h40;
        end
    end

    // Output-stationary PE grid: A flows east, B flows south, one register per hop.
    real        acc [N][N];
    logic [7:0] ar [N][N];
    logic [7:0] br [N][N];
    logic [7:0] ai, bi;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                ai = (j == 0) ? arr_a_west[8*i +: 8]  : ar[i][(j == 0) ? 0 : j - 1];
                bi = (i == 0) ? arr_b_north[8*j +: 8] : br[(i == 0) ? 0 : i - 1][j];
                ar[i][j]  <= rst ? 8'h00 : ai;
                br[i][j]  <= rst ? 8'h00 : bi;
                acc[i][j] <= arr_clear ? 0.0 : acc[i][j] + fp8r(ai) * fp8r(bi);
            end
        end
    end

    always_comb begin
        arr_c_row = '0;
        for (int j = 0; j < N; j++) arr_c_row[16*j +: 16] = bf16(acc[arr_row_sel][j]);
    end

    logic [15:0] exp_c [N][N];

    function automatic logic [63:0] exp_row(input int r);
        logic [63:0] v;
        for (int j = 0; j < N; j++) v[16*j +: 16] = exp_c[r][j];
        return v;
    endfunction

    task automatic compute_ref(input int k);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                real s;
                s = 0.0;
                for (int kk = 0; kk < k; kk++) s = s + fp8r(a_mem[kk][i]) * fp8r(b_mem[kk][j]);
                exp_c[i][j] = bf16(s);
            end
        end
    endtask

    task automatic run_job(input int k, input bit stall, input bit poke);
        int cyc, rds, rows, stall_n, busy_n, t_exp;
        bit got_done;
        t_exp = 1 + ((k > 0) ? k + 2 * N : 0) + N * (stall ? 3 : 1) + 1;
        @(negedge clk);
        start   = 1'b1;
        k_len   = KW'(k);
        c_ready = !stall;
        @(negedge clk);
        start    = 1'b0;
        k_len    = 8'hAA;
        cyc      = 1;
        rds      = 0;
        rows     = 0;
        stall_n  = 0;
        busy_n   = 0;
        got_done = 1'b0;
        while (!got_done && cyc <= t_exp + 20) begin
            if (busy) busy_n++;
            if (op_rd_en) begin
                chk("rd_addr", 64'(op_rd_addr), 64'(rds));
                rds++;
            end
            if (c_valid) begin
                chk("c_row", 64'(c_row), 64'(rows));
                chk("row_sel", 64'(arr_row_sel), 64'(rows));
                chk("c_data", c_data, exp_row(rows % N));
                if (!stall) begin
                    rows++;
                end else if (stall_n < 2) begin
                    c_ready = 1'b0;
                    stall_n++;
                end else begin
                    c_ready = 1'b1;
                    stall_n = 0;
                    rows++;
                end
            end
            if (done) begin
                got_done = 1'b1;
                chk("done_latency", 64'(cyc), 64'(t_exp));
                chk("busy_cycles", 64'(busy_n), 64'(t_exp));
                chk("rows_delivered", 64'(rows), 64'(N));
                chk("reads", 64'(rds), 64'(k));
`ifdef MMU_SEQ_PERF_EN
                @(negedge clk);
                cyc++;
                chk("perf_cycles", 64'(perf_cycles), 64'(t_exp));
`else
                chk("perf_cycles", 64'(perf_cycles), 64'd0);
`endif
            end
            start = poke && (cyc == k + 3 || cyc == t_exp - 2);
            k_len = 8'h05;
            if (!got_done) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("done_seen", 64'(got_done), 64'd1);
        start   = 1'b0;
        c_ready = 1'b1;
`ifndef MMU_SEQ_PERF_EN
        @(negedge clk);
`endif
        chk("idle_after", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        chk("stays_idle", {62'd0, busy, op_rd_en}, 64'd0);
    endtask

    typedef struct {
        int          k;
        logic [7:0]  a_diag;
        logic [7:0]  a_off;
        logic [7:0]  b_val;
        bit          stall;
        bit          poke;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{4, 8'h38, 8'h38, 8'h38, 1'b0, 1'b0, 16'h4080};
        tbl[1] = '{4, 8'h38, 8'h00, 8'h40, 1'b0, 1'b0, 16'h4000};
        tbl[2] = '{4, 8'h38, 8'h00, 8'h40, 1'b0, 1'b0, 16'h4000};
        tbl[3] = '{0, 8'h38, 8'h38, 8'h38, 1'b0, 1'b0, 16'h0000};
        tbl[4] = '{4, 8'h38, 8'h38, 8'h38, 1'b1, 1'b0, 16'h4080};
        tbl[5] = '{3, 8'h40, 8'h40, 8'h40, 1'b0, 1'b1, 16'h4140};
        tbl[6] = '{8, 8'h38, 8'h38, 8'h38, 1'b0, 1'b0, 16'h4100};

        rst     = 1'b1;
        start   = 1'b0;
        k_len   = '0;
        c_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {59'd0, busy, done, op_rd_en, arr_clear, c_valid}, 64'd0);
        chk("rst_addr_row", {54'd0, op_rd_addr, c_row}, 64'd0);
        chk("rst_lanes", {arr_a_west, arr_b_north}, 64'd0);
        chk("rst_perf", 64'(perf_cycles), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 7; t++) begin
            for (int kk = 0; kk < MAXK; kk++) begin
                for (int i = 0; i < N; i++) begin
                    a_mem[kk][i] = (i == kk) ? tbl[t].a_diag : tbl[t].a_off;
                    b_mem[kk][i] = tbl[t].b_val;
                end
            end
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) exp_c[i][j] = tbl[t].exp;
            run_job(tbl[t].k, tbl[t].stall, tbl[t].poke);
        end

        // Abort mid-FEED with reset, then a fresh job must see no stale products.
        for (int kk = 0; kk < MAXK; kk++)
            for (int i = 0; i < N; i++) begin
                a_mem[kk][i] = 8'h38;
                b_mem[kk][i] = 8'h38;
            end
        @(negedge clk);
        start = 1'b1;
        k_len = 8'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ctrl", {61'd0, busy, op_rd_en, c_valid}, 64'd0);
        chk("abort_lanes", {arr_a_west, arr_b_north}, 64'd0);
        begin
            bit saw_done;
            saw_done = 1'b0;
            repeat (20) begin
                @(negedge clk);
                if (done) saw_done = 1'b1;
            end
            chk("abort_no_done", 64'(saw_done), 64'd0);
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) exp_c[i][j] = 16'h4000;
        run_job(2, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int k;
            k = $urandom_range(1, 10);
            for (int kk = 0; kk < MAXK; kk++)
                for (int i = 0; i < N; i++) begin
                    logic [7:0] x, y;
                    x = 8'($urandom_range(0, 255));
                    y = 8'($urandom_range(0, 255));
                    a_mem[kk][i] = (x[6:0] == 7'h7F) ? 8'h00 : x;
                    b_mem[kk][i] = (y[6:0] == 7'h7F) ? 8'h00 : y;
                end
            compute_ref(k);
            run_job(k, r[0], 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
